// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Owns the PC, issues word requests to
// instruction memory, buffers responses in a DEPTH-entry in-order queue and
// hands them to decode over a valid/ready handshake. A redirect flushes the
// queue and discards responses that are still in flight.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN (sticky misaligned-redirect
// flag that halts fetching until reset). Without it the redirect target is
// forced word-aligned and fetch_misalign is tied low.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        valid,
  output logic [31:0] instruction,
  output logic [31:0] pc_address,
  input  logic        dec_ready,
  output logic        fetch_misalign
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [31:0]   pc_q, pc_d;
  logic [PW-1:0] alloc_q, alloc_d, fill_q, fill_d, head_q, head_d;
  logic [CW-1:0] count_q, count_d, pend_q, pend_d, drop_q, drop_d;
  logic [CW-1:0] in_flight;

  logic [31:0]    slot_pc_q    [DEPTH];
  logic [31:0]    slot_instr_q [DEPTH];
  logic [DEPTH-1:0] slot_filled_q;

  logic        accept, pop, rsp_drop, rsp_fill, halted;
  logic [31:0] redir_pc;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misalign_q, misalign_d;

  assign redir_pc   = redirect_pc;
  assign misalign_d = misalign_q | (redirect & (|redirect_pc[1:0]));
  assign halted     = misalign_q;

  // Sticky misalignment flag; only reset clears it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) misalign_q <= 1'b0;
    else      misalign_q <= misalign_d;
  end

  assign fetch_misalign = misalign_q;
`else
  assign redir_pc       = redirect_pc & 32'hFFFF_FFFC;
  assign halted         = 1'b0;
  assign fetch_misalign = 1'b0;
`endif

  assign imem_req_valid = rst && (count_q < FULL) && !redirect &&
                          (drop_q == '0) && !halted;
  assign imem_req_addr  = pc_q;
  assign accept         = imem_req_valid && imem_req_ready;

  assign valid       = slot_filled_q[head_q];
  assign instruction = slot_instr_q[head_q];
  assign pc_address  = slot_pc_q[head_q];
  assign pop         = valid && dec_ready;

  assign rsp_drop = imem_rsp_valid && (drop_q != '0);
  assign rsp_fill = imem_rsp_valid && (drop_q == '0) && (pend_q != '0);

  // Stale responses = earlier drops plus still-pending fetches; both are never
  // non-zero together, so a redirect during a drop window keeps the tally exact
  assign in_flight = drop_q + pend_q;

  // Next-state for PC, pointers and counters; redirect overrides everything
  always_comb begin
    pc_d    = pc_q;
    alloc_d = alloc_q;
    fill_d  = fill_q;
    head_d  = head_q;
    count_d = count_q;
    pend_d  = pend_q;
    drop_d  = drop_q;
    if (redirect) begin
      pc_d    = redir_pc;
      alloc_d = '0;
      fill_d  = '0;
      head_d  = '0;
      count_d = '0;
      pend_d  = '0;
      drop_d  = (imem_rsp_valid && (in_flight != '0)) ? in_flight - 1'b1 : in_flight;
    end else begin
      if (accept) begin
        pc_d    = pc_q + 32'd4;
        alloc_d = alloc_q + 1'b1;
      end
      if (rsp_drop) drop_d = drop_q - 1'b1;
      if (rsp_fill) fill_d = fill_q + 1'b1;
      if (pop)      head_d = head_q + 1'b1;
      count_d = count_q + CW'(accept) - CW'(pop);
      pend_d  = pend_q + CW'(accept) - CW'(rsp_fill);
    end
  end

  // PC, pointer and counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q    <= RESET_PC;
      alloc_q <= '0;
      fill_q  <= '0;
      head_q  <= '0;
      count_q <= '0;
      pend_q  <= '0;
      drop_q  <= '0;
    end else begin
      pc_q    <= pc_d;
      alloc_q <= alloc_d;
      fill_q  <= fill_d;
      head_q  <= head_d;
      count_q <= count_d;
      pend_q  <= pend_d;
      drop_q  <= drop_d;
    end
  end

  // Queue slot storage: allocate, fill from memory, free on pop, flush on redirect
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        slot_pc_q[i]    <= '0;
        slot_instr_q[i] <= '0;
      end
      slot_filled_q <= '0;
    end else if (redirect) begin
      slot_filled_q <= '0;
    end else begin
      if (accept) begin
        slot_pc_q[alloc_q]     <= pc_q;
        slot_filled_q[alloc_q] <= 1'b0;
      end
      if (rsp_fill) begin
        slot_instr_q[fill_q]  <= imem_rsp_data;
        slot_filled_q[fill_q] <= 1'b1;
      end
      if (pop) slot_filled_q[head_q] <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit with a behavioural in-order memory of
// configurable latency. Instruction words are address ^ K.
module tb_fetch_unit;

  localparam logic [31:0] K = 32'hA5A5_0F0F;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        valid;
  logic [31:0] instruction, pc_address;
  logic        dec_ready;
  logic        fetch_misalign;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
  } mreq_t;
  mreq_t       mq[$];
  int unsigned cyc;
  int unsigned mem_lat;

  typedef struct {
    logic        dec;
    logic        rdy;
    logic        exp_rv;
    logic [31:0] exp_addr;
    logic        exp_v;
    logic [31:0] exp_pc;
  } vec_t;
  vec_t vt[13];

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0100), .DEPTH(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .valid          (valid),
    .instruction    (instruction),
    .pc_address     (pc_address),
    .dec_ready      (dec_ready),
    .fetch_misalign (fetch_misalign)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic settle();
    #1;
  endtask

  // One clock: record the handshake, cross the edge, then drive the memory response
  task automatic cycle();
    logic        acc;
    logic [31:0] a;
    #2;
    acc = imem_req_valid & imem_req_ready;
    a   = imem_req_addr;
    @(posedge clk);
    #1;
    cyc++;
    if (acc) mq.push_back('{a, cyc + mem_lat - 1});
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mq[0].addr ^ K;
      void'(mq.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  endtask

  task automatic do_reset(input int unsigned lat);
    rst            = 1'b0;
    redirect       = 1'b0;
    redirect_pc    = '0;
    dec_ready      = 1'b1;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    mem_lat        = lat;
    mq.delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst.req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("rst.req_addr", imem_req_addr, 32'h100);
    check("rst.valid", {31'd0, valid}, 32'd0);
    check("rst.instruction", instruction, 32'd0);
    check("rst.pc_address", pc_address, 32'd0);
    check("rst.misalign", {31'd0, fetch_misalign}, 32'd0);
    rst = 1'b1;
    cyc = 0;
  endtask

  task automatic wait_valid(input string name, input logic [31:0] exp_pc, input int exp_n);
    int n = 0;
    while (!valid && n < 30) begin
      cycle();
      settle();
      n++;
    end
    check({name, ".valid"}, {31'd0, valid}, 32'd1);
    check({name, ".latency"}, n, exp_n);
    check({name, ".pc"}, pc_address, exp_pc);
    check({name, ".instr"}, instruction, exp_pc ^ K);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Streaming with a 1-cycle memory, then a short decode stall
    vt[0]  = '{1'b1, 1'b1, 1'b1, 32'h100, 1'b0, 32'h000};
    vt[1]  = '{1'b1, 1'b1, 1'b1, 32'h104, 1'b0, 32'h000};
    vt[2]  = '{1'b1, 1'b1, 1'b1, 32'h108, 1'b1, 32'h100};
    vt[3]  = '{1'b1, 1'b1, 1'b1, 32'h10C, 1'b1, 32'h104};
    vt[4]  = '{1'b1, 1'b1, 1'b1, 32'h110, 1'b1, 32'h108};
    vt[5]  = '{1'b1, 1'b1, 1'b1, 32'h114, 1'b1, 32'h10C};
    vt[6]  = '{1'b0, 1'b1, 1'b1, 32'h118, 1'b1, 32'h110};
    vt[7]  = '{1'b0, 1'b1, 1'b1, 32'h11C, 1'b1, 32'h110};
    vt[8]  = '{1'b1, 1'b1, 1'b0, 32'h120, 1'b1, 32'h110};
    vt[9]  = '{1'b1, 1'b1, 1'b1, 32'h120, 1'b1, 32'h114};
    vt[10] = '{1'b1, 1'b1, 1'b1, 32'h124, 1'b1, 32'h118};
    vt[11] = '{1'b1, 1'b1, 1'b1, 32'h128, 1'b1, 32'h11C};
    vt[12] = '{1'b1, 1'b1, 1'b1, 32'h12C, 1'b1, 32'h120};

    do_reset(1);
    for (int i = 0; i < 13; i++) begin
      dec_ready      = vt[i].dec;
      imem_req_ready = vt[i].rdy;
      settle();
      check($sformatf("vec%0d.req_valid", i), {31'd0, imem_req_valid}, {31'd0, vt[i].exp_rv});
      check($sformatf("vec%0d.req_addr", i), imem_req_addr, vt[i].exp_addr);
      check($sformatf("vec%0d.valid", i), {31'd0, valid}, {31'd0, vt[i].exp_v});
      if (vt[i].exp_v) begin
        check($sformatf("vec%0d.pc", i), pc_address, vt[i].exp_pc);
        check($sformatf("vec%0d.instr", i), instruction, vt[i].exp_pc ^ K);
      end
      cycle();
    end

    // Decode stalled for 10 cycles: fill to DEPTH, head holds, then drain in order
    do_reset(1);
    dec_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      settle();
      check($sformatf("stall%0d.req_valid", i), {31'd0, imem_req_valid}, (i < 4) ? 32'd1 : 32'd0);
      if (i >= 2) begin
        check($sformatf("stall%0d.valid", i), {31'd0, valid}, 32'd1);
        check($sformatf("stall%0d.pc", i), pc_address, 32'h100);
      end
      cycle();
    end
    dec_ready = 1'b1;
    settle();
    check("drain.credit_next_cycle", {31'd0, imem_req_valid}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) settle();
      check($sformatf("drain%0d.valid", i), {31'd0, valid}, 32'd1);
      check($sformatf("drain%0d.pc", i), pc_address, 32'h100 + 32'(4 * i));
      check($sformatf("drain%0d.instr", i), instruction, (32'h100 + 32'(4 * i)) ^ K);
      cycle();
    end

    // Redirect with two fetches outstanding (3-cycle memory)
    do_reset(3);
    settle();
    check("redirA.c0.addr", imem_req_addr, 32'h100);
    cycle();
    settle();
    check("redirA.c1.addr", imem_req_addr, 32'h104);
    cycle();
    redirect = 1'b1;
    redirect_pc = 32'h200;
    settle();
    check("redirA.c2.req_valid", {31'd0, imem_req_valid}, 32'd0);
    cycle();
    redirect = 1'b0;
    for (int i = 3; i < 5; i++) begin
      settle();
      check($sformatf("redirA.c%0d.req_valid", i), {31'd0, imem_req_valid}, 32'd0);
      check($sformatf("redirA.c%0d.valid", i), {31'd0, valid}, 32'd0);
      cycle();
    end
    settle();
    check("redirA.c5.req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("redirA.c5.addr", imem_req_addr, 32'h200);
    wait_valid("redirA.first", 32'h200, 4);

    // Redirect in the same cycle as a response: that response counts as dropped
    do_reset(3);
    cycle(); cycle(); cycle();
    redirect = 1'b1;
    redirect_pc = 32'h300;
    settle();
    cycle();
    redirect = 1'b0;
    for (int i = 4; i < 6; i++) begin
      settle();
      check($sformatf("redirB.c%0d.req_valid", i), {31'd0, imem_req_valid}, 32'd0);
      cycle();
    end
    settle();
    check("redirB.c6.req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("redirB.c6.addr", imem_req_addr, 32'h300);
    wait_valid("redirB.first", 32'h300, 4);

    // Memory not ready for 3 cycles: address held, no skip or duplicate
    do_reset(1);
    imem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check($sformatf("nrdy%0d.req_valid", i), {31'd0, imem_req_valid}, 32'd1);
      check($sformatf("nrdy%0d.addr", i), imem_req_addr, 32'h100);
      cycle();
    end
    imem_req_ready = 1'b1;
    settle();
    check("nrdy3.addr", imem_req_addr, 32'h100);
    cycle();
    settle();
    check("nrdy4.addr", imem_req_addr, 32'h104);
    cycle();
    settle();
    check("nrdy5.pc", pc_address, 32'h100);
    cycle();
    settle();
    check("nrdy6.pc", pc_address, 32'h104);

    // PC wrap from 0xFFFF_FFFC to 0
    do_reset(1);
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    settle();
    check("wrap.c0.req_valid", {31'd0, imem_req_valid}, 32'd0);
    cycle();
    redirect = 1'b0;
    settle();
    check("wrap.c1.addr", imem_req_addr, 32'hFFFF_FFFC);
    cycle();
    settle();
    check("wrap.c2.addr", imem_req_addr, 32'h0000_0000);
    cycle();
    settle();
    check("wrap.c3.pc", pc_address, 32'hFFFF_FFFC);
    cycle();
    settle();
    check("wrap.c4.pc", pc_address, 32'h0000_0000);
    check("wrap.c4.instr", instruction, 32'h0000_0000 ^ K);

    // Misaligned redirect target
    do_reset(1);
    redirect = 1'b1;
    redirect_pc = 32'h202;
    settle();
    cycle();
    redirect = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    for (int i = 1; i < 5; i++) begin
      settle();
      check($sformatf("mis%0d.flag", i), {31'd0, fetch_misalign}, 32'd1);
      check($sformatf("mis%0d.req_valid", i), {31'd0, imem_req_valid}, 32'd0);
      check($sformatf("mis%0d.valid", i), {31'd0, valid}, 32'd0);
      cycle();
    end
`else
    settle();
    check("mis1.flag", {31'd0, fetch_misalign}, 32'd0);
    check("mis1.req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("mis1.addr", imem_req_addr, 32'h200);
    wait_valid("mis.first", 32'h200, 2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage that produces the instruction stream consumed by the decode stage. It owns the PC and issues word requests to instruction memory over a request/response handshake. Responses are buffered in a DEPTH-entry in-order queue and presented to decode with a valid/ready handshake. On a taken branch or jump resolved downstream, it flushes and redirects.

## Interface
- RESET_PC, 32'h0000_0000, PC of the first fetch after reset.
- DEPTH, 4, queue entries (power of two, ≥2); bounds outstanding plus buffered fetches.

- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset; 0 = reset.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request this cycle.
- imem_req_addr  output  32  word-aligned fetch address; always equals the internal PC.
- imem_rsp_valid  input  1  response data valid. Responses are in order, at least 1 cycle after acceptance, and never back-pressured.
- imem_rsp_data  input  32  instruction word.
- redirect  input  1  flush and restart fetch (taken branch, jal, or jalr).
- redirect_pc  input  32  new fetch PC.
- valid  output  1  instruction and pc_address valid toward decode.
- instruction  output  32  head instruction.
- pc_address  output  32  PC of head instruction.
- dec_ready  input  1  decode consumes the head this cycle (0 = stall / load-use hold).
- fetch_misalign  output  1  sticky misaligned-redirect flag; constant 0 without the macro.

## Operation
- State:
  - PC register.
  - Queue of DEPTH slots, each holding {pc, instr, filled}, with alloc, fill and head pointers.
  - Count of allocated slots.
  - Drop counter, width clog2(DEPTH)+1.
- Request:
  - imem_req_valid = 1 when count < DEPTH, redirect = 0, drop = 0 and not halted.
  - Handshake (valid & ready):
    - allocate a slot and write its pc = PC, filled = 0;
    - PC += 4, 32-bit wrap (32'hFFFF_FFFC → 0).
- Response:
  - If drop > 0, discard the response and decrement drop.
  - Otherwise write imem_rsp_data into the fill slot, set filled = 1, advance the fill pointer.
- Output:
  - valid = head slot filled.
  - instruction and pc_address come from the head slot.
  - When valid & dec_ready, free the head slot and decrement count.
- Redirect (highest priority):
  - Clear all filled bits, reset the pointers, set count = 0, PC = redirect_pc.
  - drop = number of slots allocated but not filled, minus 1 if imem_rsp_valid that same cycle. A response arriving in the redirect cycle is discarded.
  - No request is issued in the redirect cycle.
  - A head pop in the same cycle is treated as consumed by decode.
- Simultaneous allocate and pop: count unchanged. A freed slot becomes available to requests the following cycle, because credit is taken from the registered count.
- Full queue (count = DEPTH): imem_req_valid = 0 and the PC holds.
- Empty queue: valid = 0.

## Timing
- Reset values while rst = 0:
  - PC = RESET_PC;
  - all slots pc = 0, instr = 0, filled = 0; count = 0; drop = 0;
  - imem_req_valid = 0, valid = 0, instruction = 0, pc_address = 0, fetch_misalign = 0.
- First request: the first rising edge after rst deasserts, with imem_req_addr = RESET_PC.
- Reset asserted mid-operation clears everything immediately (asynchronous). Responses still in flight at that point are not tracked; memory must be reset together with this block.
- Latency:
  - request accepted at cycle N, response at N+1 → valid at N+2;
  - the slot is reusable by a request at N+3 if popped at N+2.
- Throughput: one instruction per cycle with a 1-cycle memory requires DEPTH ≥ 3.
- Redirect:
  - redirect at cycle R → imem_req_addr = redirect_pc with imem_req_valid = 1 at R+1, provided drop = 0;
  - otherwise requests resume the cycle after the last stale response is dropped.

## Configuration
- FETCH_MISALIGN_CHECK_EN defined:
  - a redirect with redirect_pc[1:0] ≠ 0 still flushes;
  - it then sets fetch_misalign = 1 and halts requests until reset;
  - valid stays 0.
- Macro undefined:
  - redirect_pc[1:0] is forced to 2'b00;
  - fetch_misalign is tied 0.

## Test plan
- Reset with RESET_PC = 32'h100, 1-cycle memory, dec_ready = 1:
  - requests go to 0x100, 0x104, 0x108, …;
  - valid rises 2 cycles after the first accept and then stays high every cycle.
- dec_ready = 0 for 10 cycles:
  - requests stop after DEPTH allocations;
  - head pc_address = 0x100 holds steady;
  - after release, all DEPTH entries drain in order.
- Redirect to 0x200 while 2 requests are outstanding:
  - the 2 stale responses are dropped and valid stays 0 meanwhile;
  - the next valid shows pc_address = 0x200.
- imem_req_ready held 0 for 3 cycles: imem_req_addr stays constant, with no duplicate or skipped PC.
- PC = 32'hFFFF_FFFC: the next request address wraps to 32'h0000_0000.
- Redirect to 0x202:
  - with FETCH_MISALIGN_CHECK_EN, fetch_misalign = 1 and no further requests;
  - without it, the fetch goes to 0x200.
